// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_tick marks the last clock of each CLKS_PER_BIT period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises them as UART frames (LSB first).
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       rd_empty,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    tx_state_e  state, state_d;
    logic [7:0] sreg, sreg_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic       parity, parity_d;
    logic       bit_tick, baud_clear;
    logic       tx_d, rd_en_d, busy_d, done_d;

    assign baud_clear = (state == S_IDLE) || (state == S_FETCH) || (state == S_LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        bit_cnt_d = bit_cnt;
        parity_d  = parity;
        case (state)
            S_IDLE: begin
                if (tx_en && !rd_empty) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                sreg_d    = rd_data;
                parity_d  = ^rd_data;
                bit_cnt_d = '0;
                state_d   = S_START;
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick) begin
                    sreg_d    = {1'b0, sreg[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
            S_STOP: begin
                // bit_cnt is 0 on entry and counts completed stop bits
                if (bit_tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        tx_d = IDLE_LEVEL;
        case (state_d)
            S_START:  tx_d = START_LEVEL;
            S_DATA:   tx_d = sreg_d[0];
            S_PARITY: tx_d = parity;
            default:  tx_d = IDLE_LEVEL;
        endcase
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state == S_STOP) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            parity    <= 1'b0;
            tx        <= IDLE_LEVEL;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            bit_cnt   <= bit_cnt_d;
            parity    <= parity_d;
            tx        <= tx_d;
            rd_en     <= rd_en_d;
            busy      <= busy_d;
            byte_done <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitter configurations, each fed by a small FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       tx_en0, tx_en1, tx_en2;
    logic       rd_en0, rd_en1, rd_en2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       bd0, bd1, bd2;
    logic [7:0] rd_data0, rd_data1, rd_data2;
    logic       empty0, empty1, empty2;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [3:0] wr0, wr1, wr2;
    logic [3:0] rd0 = '0, rd1 = '0, rd2 = '0;
    int         dn0 = 0, dn1 = 0, dn2 = 0;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);
    assign empty2 = (wr2 == rd2);

    // FIFO models: data appears the cycle after a sampled pop
    always @(posedge clk) if (rd_en0) begin rd_data0 <= mem0[rd0]; rd0 <= rd0 + 4'd1; end
    always @(posedge clk) if (rd_en1) begin rd_data1 <= mem1[rd1]; rd1 <= rd1 + 4'd1; end
    always @(posedge clk) if (rd_en2) begin rd_data2 <= mem2[rd2]; rd2 <= rd2 + 4'd1; end
    always @(posedge clk) if (bd0) dn0 <= dn0 + 1;
    always @(posedge clk) if (bd1) dn1 <= dn1 + 1;
    always @(posedge clk) if (bd2) dn2 <= dn2 + 1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_en(tx_en0), .rd_empty(empty0), .rd_en(rd_en0),
        .rd_data(rd_data0), .tx(tx0), .busy(busy0), .byte_done(bd0));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .rd_empty(empty1), .rd_en(rd_en1),
        .rd_data(rd_data1), .tx(tx1), .busy(busy1), .byte_done(bd1));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .rd_empty(empty2), .rd_en(rd_en2),
        .rd_data(rd_data2), .tx(tx2), .busy(busy2), .byte_done(bd2));

    int   sel;
    logic tx_s, busy_s, rd_en_s, bd_s;
    always_comb begin
        tx_s = tx0; busy_s = busy0; rd_en_s = rd_en0; bd_s = bd0;
        case (sel)
            1: begin tx_s = tx1; busy_s = busy1; rd_en_s = rd_en1; bd_s = bd1; end
            2: begin tx_s = tx2; busy_s = busy2; rd_en_s = rd_en2; bd_s = bd2; end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] b);
        case (s)
            0: begin mem0[wr0] = b; wr0 = wr0 + 4'd1; end
            1: begin mem1[wr1] = b; wr1 = wr1 + 4'd1; end
            default: begin mem2[wr2] = b; wr2 = wr2 + 4'd1; end
        endcase
    endtask

    task automatic set_en(input int s, input logic v);
        case (s)
            0: tx_en0 = v;
            1: tx_en1 = v;
            default: tx_en2 = v;
        endcase
    endtask

    // Waits for the start bit, then checks every cycle of the frame and the byte_done cycle.
    task automatic frame(input string tag, input logic [11:0] pat, input int nbits,
                         input int exp_wait, input int drop_at);
        int   n;
        logic bad;
        logic seen;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_s !== 1'b0 && n < 200);
        check({tag, "_start"}, {31'd0, tx_s}, 32'd0);
        check({tag, "_latency"}, n, exp_wait);
        for (int b = 0; b < nbits; b++) begin
            bad  = 1'b0;
            seen = pat[b];
            for (int k = 0; k < CPB; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (b * CPB + k == drop_at) set_en(sel, 1'b0);
                if (tx_s !== pat[b] && !bad) begin bad = 1'b1; seen = tx_s; end
                if (bd_s !== 1'b0 || busy_s !== 1'b1 || rd_en_s !== 1'b0) begin
                    bad  = 1'b1;
                    seen = ~pat[b];
                end
            end
            check($sformatf("%s_bit%0d", tag, b), {31'd0, seen}, {31'd0, pat[b]});
        end
        @(negedge clk);
        check({tag, "_done"}, {29'd0, bd_s, busy_s, tx_s}, 32'b101);
    endtask

    logic [3:0] rd_base;
    int         dn_base;
    int         n;
    logic       ok;

    initial begin
        rst = 1'b1; tx_en0 = 1'b0; tx_en1 = 1'b0; tx_en2 = 1'b0;
        wr0 = '0; wr1 = '0; wr2 = '0; sel = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", {28'd0, tx0, busy0, rd_en0, bd0}, 32'b1000);
        check("reset_outs_c", {28'd0, tx2, busy2, rd_en2, bd2}, 32'b1000);
        rst = 1'b0;

        // Empty FIFO with tx_en high: nothing may happen
        tx_en0 = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rd_en0 !== 1'b0 || busy0 !== 1'b0) ok = 1'b0;
        end
        check("empty_idle", {31'd0, ok}, 32'd1);
        tx_en0 = 1'b0;

        // Single frame, 0xA5, no parity, one stop bit
        sel = 0; rd_base = rd0; dn_base = dn0;
        push(0, 8'hA5); tx_en0 = 1'b1;
        @(negedge clk);
        check("fetch_rd_en", {30'd0, rd_en0, busy0}, 32'b11);
        @(negedge clk);
        check("load_rd_en", {30'd0, rd_en0, tx0}, 32'b01);
        frame("a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1, -1);
        tx_en0 = 1'b0;
        @(negedge clk);
        check("a5_pops", {28'd0, rd0 - rd_base}, 32'd1);
        check("a5_dones", dn0 - dn_base, 32'd1);

        // Even parity: 0xA5 -> 0, 0x07 -> 1, back to back
        sel = 1; rd_base = rd1; dn_base = dn1;
        push(1, 8'hA5); push(1, 8'h07); tx_en1 = 1'b1;
        frame("par_a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 3, -1);
        frame("par_07", {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 3, -1);
        tx_en1 = 1'b0;
        @(negedge clk);
        check("par_pops", {28'd0, rd1 - rd_base}, 32'd2);
        check("par_dones", dn1 - dn_base, 32'd2);

        // Two stop bits, three queued bytes, tx_en held
        sel = 2; rd_base = rd2; dn_base = dn2;
        tx_en2 = 1'b1;
        push(2, 8'h5A); push(2, 8'h01); push(2, 8'hFF);
        frame("s2_5a", {1'b0, 2'b11, 8'h5A, 1'b0}, 11, 3, -1);
        frame("s2_01", {1'b0, 2'b11, 8'h01, 1'b0}, 11, 3, -1);
        frame("s2_ff", {1'b0, 2'b11, 8'hFF, 1'b0}, 11, 3, -1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy2 !== 1'b0 || rd_en2 !== 1'b0 || tx2 !== 1'b1) ok = 1'b0;
        end
        check("s2_stays_idle", {31'd0, ok}, 32'd1);
        check("s2_pops", {28'd0, rd2 - rd_base}, 32'd3);
        check("s2_dones", dn2 - dn_base, 32'd3);
        tx_en2 = 1'b0;

        // Reset during data bit 3 abandons the frame
        sel = 0; rd_base = rd0; dn_base = dn0;
        push(0, 8'hF0); tx_en0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tx0 !== 1'b0 && n < 200);
        check("rst_frame_start", {31'd0, tx0}, 32'd0);
        repeat (17) @(negedge clk);
        check("rst_in_bit3", {30'd0, busy0, tx0}, 32'b10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outs", {29'd0, tx0, busy0, rd_en0}, 32'b100);
        @(negedge clk);
        rst = 1'b0;
        push(0, 8'h3C);
        frame("after_rst", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 3, -1);
        @(negedge clk);
        check("rst_pops", {28'd0, rd0 - rd_base}, 32'd2);
        check("rst_dones", dn0 - dn_base, 32'd1);

        // tx_en dropped mid-frame: frame completes, no further pop until re-enabled
        rd_base = rd0;
        push(0, 8'h81); push(0, 8'h42);
        frame("drop_81", {2'b00, 1'b1, 8'h81, 1'b0}, 10, 3, 20);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || rd_en0 !== 1'b0) ok = 1'b0;
        end
        check("drop_held_idle", {31'd0, ok}, 32'd1);
        check("drop_pops", {28'd0, rd0 - rd_base}, 32'd1);
        tx_en0 = 1'b1;
        frame("resume_42", {2'b00, 1'b1, 8'h42, 1'b0}, 10, 3, -1);
        tx_en0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
